// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the LDR/STR memory access sequencer.
// The optional alignment check is enabled by defining MEM_ALIGN_CHECK_EN.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int ACK_TIMEOUT_DEF = 15;
    localparam int OFFSET_W_DEF    = 12;

    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr & ALIGN_MASK) != 32'h0000_0000;
    endfunction

endpackage

// File: rtl/mem_addr_calc.sv
// Combinational effective-address adder: base +/- zero-extended offset, with
// pre/post-index selection of the address actually presented to RAM.
module mem_addr_calc
    import mem_ctrl_pkg::*;
#(
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic [31:0]         base_addr,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                offset_up,
    input  logic                pre_index,
    output logic [31:0]         eff,
    output logic [31:0]         acc_addr
);

    logic [31:0] off_ext_s;

    assign off_ext_s = 32'(offset);

    // Add or subtract the offset; wrap-around modulo 2^32 is intentional.
    always_comb begin
        eff = base_addr;
        if (offset_up) begin
            eff = base_addr + off_ext_s;
        end else begin
            eff = base_addr - off_ext_s;
        end
    end

    // Post-index accesses use the unmodified base.
    always_comb begin
        acc_addr = base_addr;
        if (pre_index) begin
            acc_addr = eff;
        end else begin
            acc_addr = base_addr;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LDR/STR access sequencer driving the address bus mux and RAM strobes.
// Define MEM_ALIGN_CHECK_EN to abort accesses whose address bits [1:0] are nonzero.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int OFFSET_W    = OFFSET_W_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                is_load,
    input  logic                is_store,
    input  logic [31:0]         base_addr,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                offset_up,
    input  logic                pre_index,
    input  logic                writeback,
    input  logic [31:0]         store_data,
    output logic                addr_sel,
    output logic [31:0]         mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    input  logic                mem_ack,
    output logic                done,
    output logic                err,
    output logic [31:0]         load_data,
    output logic                wb_valid,
    output logic [31:0]         wb_addr,
    output logic                stall
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [31:0]        calc_eff_s;
    logic [31:0]        calc_acc_s;
    logic [31:0]        acc_r;
    logic [31:0]        eff_r;
    logic [31:0]        wdata_r;
    logic               load_r;
    logic               store_r;
    logic               wb_req_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               nop_s;
    logic               misalign_s;
    logic               timeout_s;
    logic               fail_s;
    logic               drive_addr_s;
    logic [31:0]        addr_src_s;
    logic [31:0]        eff_src_s;

    mem_addr_calc #(.OFFSET_W(OFFSET_W)) u_addr_calc (
        .base_addr (base_addr),
        .offset    (offset),
        .offset_up (offset_up),
        .pre_index (pre_index),
        .eff       (calc_eff_s),
        .acc_addr  (calc_acc_s)
    );

    assign nop_s     = !(is_load || is_store);
    assign timeout_s = (cnt_r == CNT_W'(ACK_TIMEOUT));

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_s = is_misaligned(acc_r);
`else
    assign misalign_s = 1'b0;
`endif

    // Stall is combinational on req_valid so the PC freezes in the accept cycle.
    assign stall = busy_r || (req_ready && req_valid);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic and abort detection.
    always_comb begin
        next_state_s = state_r;
        fail_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = nop_s ? ST_DONE : ST_ADDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (misalign_s) begin
                    next_state_s = ST_DONE;
                    fail_s       = 1'b1;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    next_state_s = ST_DONE;
                end else if (timeout_s) begin
                    next_state_s = ST_DONE;
                    fail_s       = 1'b1;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // In the accept cycle the request is latched at the same edge, so use the live adder.
    always_comb begin
        addr_src_s = acc_r;
        eff_src_s  = eff_r;
        if (state_r == ST_IDLE) begin
            addr_src_s = calc_acc_s;
            eff_src_s  = calc_eff_s;
        end else begin
            addr_src_s = acc_r;
            eff_src_s  = eff_r;
        end
    end

    assign drive_addr_s = (next_state_s == ST_ADDR) || (next_state_s == ST_ACCESS);

    // Request latch; a load+store request is handled as a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= 32'h0000_0000;
            eff_r    <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            load_r   <= 1'b0;
            store_r  <= 1'b0;
            wb_req_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            acc_r    <= calc_acc_s;
            eff_r    <= calc_eff_s;
            wdata_r  <= store_data;
            load_r   <= is_load;
            store_r  <= is_store && !is_load;
            wb_req_r <= writeback || !pre_index;
        end else begin
            acc_r    <= acc_r;
            eff_r    <= eff_r;
            wdata_r  <= wdata_r;
            load_r   <= load_r;
            store_r  <= store_r;
            wb_req_r <= wb_req_r;
        end
    end

    // Registered outputs, each decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b0;
            busy_r    <= 1'b0;
            addr_sel  <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= 32'h0000_0000;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0000_0000;
            wb_valid  <= 1'b0;
            wb_addr   <= 32'h0000_0000;
            cnt_r     <= '0;
        end else begin
            req_ready <= (next_state_s == ST_IDLE);
            busy_r    <= (next_state_s != ST_IDLE);
            addr_sel  <= drive_addr_s;
            mem_addr  <= drive_addr_s ? addr_src_s : 32'h0000_0000;
            mem_re    <= (next_state_s == ST_ACCESS) && load_r;
            mem_we    <= (next_state_s == ST_ACCESS) && store_r;
            mem_wdata <= ((next_state_s == ST_ACCESS) && store_r) ? wdata_r : 32'h0000_0000;
            done      <= (next_state_s == ST_DONE);
            err       <= (next_state_s == ST_DONE) && fail_s;
            load_data <= ((state_r == ST_ACCESS) && mem_ack && load_r) ? mem_rdata : 32'h0000_0000;
            // Only the direct IDLE->DONE path (no-op request) comes from IDLE; it never writes back.
            wb_valid  <= (next_state_s == ST_DONE) && (state_r != ST_IDLE) && wb_req_r && !fail_s;
            wb_addr   <= (next_state_s == ST_DONE) ? eff_src_s : 32'h0000_0000;
            cnt_r     <= ((state_r == ST_ACCESS) && (next_state_s == ST_ACCESS)) ? (cnt_r + CNT_W'(1)) : '0;
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for LDR/STR accesses. It sits directly upstream of the address bus mux and drives that mux's enable and address-in inputs. It computes the effective address from base and offset, holds the mux on the data address while the RAM access runs, waits for RAM acknowledge, and returns load data and base-register writeback. While busy it asserts `stall`, so the PC does not advance and the mux stays off the PC instruction address.

## Interface
- `OFFSET_W`, default 12: immediate offset width, zero-extended to 32 bits.
- `ACK_TIMEOUT`, default 15: maximum ACCESS cycles without `mem_ack` before the access is aborted.
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: decoded memory instruction present.
- `req_ready` out 1: controller can accept a request.
- `is_load` in 1: LDR.
- `is_store` in 1: STR.
- `base_addr` in 32: base register value.
- `offset` in OFFSET_W: immediate offset.
- `offset_up` in 1: 1 = add offset, 0 = subtract offset.
- `pre_index` in 1: 1 = access at base±offset, 0 = access at base.
- `writeback` in 1: write effective address back to base register.
- `store_data` in 32: STR source data.
- `addr_sel` out 1: bus mux enable (1 = data address, 0 = PC).
- `mem_addr` out 32: bus mux address-in.
- `mem_re` out 1: RAM read strobe.
- `mem_we` out 1: RAM write strobe.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data, valid when `mem_ack` = 1.
- `mem_ack` in 1: RAM access complete.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; the access was aborted.
- `load_data` out 32: captured load result, valid with `done`.
- `wb_valid` out 1: base writeback strobe, coincident with `done`.
- `wb_addr` out 32: writeback value.
- `stall` out 1: hold PC / fetch.

## Operation
- **States:** IDLE, ADDR, ACCESS, DONE. ACCESS also enters DONE on timeout or fault.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid` = 1, latch all request fields.
  - Compute `eff` = `base_addr` ± zext(`offset`), modulo 2^32. Wrap-around is silent.
  - Access address = `pre_index` ? `eff` : `base_addr`.
  - Go to ADDR.
- **Request type rules:**
  - `is_load` and `is_store` both 1: treated as load.
  - Neither set: skip to DONE with no RAM strobe, `done` = 1, `err` = 0, no writeback.
- **ADDR:**
  - `addr_sel` = 1, `mem_addr` = access address.
  - One cycle only; this lets the registered bus mux present the address to RAM.
- **ACCESS:**
  - `addr_sel` and `mem_addr` held.
  - `mem_re` (load) or `mem_we` with `mem_wdata` = latched store data, held until `mem_ack` is sampled 1.
  - On ack: load captures `mem_rdata` into `load_data`, then go to DONE.
  - Timeout counter counts from 0. If it reaches `ACK_TIMEOUT` without ack, go to DONE with `err` = 1.
- **DONE:**
  - `done` = 1 for one cycle.
  - `addr_sel` = 0, `mem_re` = 0, `mem_we` = 0.
  - `wb_valid` = (`writeback` | !`pre_index`) & !`err`, with `wb_addr` = `eff`.
  - Then IDLE. No request is accepted in DONE.
- **`stall`:** 1 in ADDR, ACCESS and DONE, and in IDLE while `req_valid` = 1.
- **Reset values:**
  - State IDLE.
  - Every output 0, except `req_ready`, which is 0 during reset and 1 in the first cycle after reset.
- **Reset mid-operation:** strobes drop at the next edge; no `done`, no writeback, latched request discarded.
- **`mem_ack` outside ACCESS:** ignored.

## Timing
- Cycle 0: accept. Cycle 1: ADDR. Cycle 2: first ACCESS cycle, address valid at RAM.
- Zero-wait RAM: `done` in cycle 3. Each wait state adds 1 cycle.
- Timeout: `done`/`err` in cycle 3 + `ACK_TIMEOUT`.
- Throughput: next accept no earlier than the cycle after DONE.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:** on accept, an access address with bits [1:0] ≠ 0 takes ADDR → DONE with `err` = 1. There is no RAM strobe and no writeback.
- **`MEM_ALIGN_CHECK_EN` undefined:** the address is passed through unchanged. RAM handles the low bits.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum;
  - the `ACK_TIMEOUT` and `OFFSET_W` defaults;
  - the alignment mask constant.
- Sub-module `mem_addr_calc`: combinational base ± offset adder. It outputs `eff` and the access address.

## Test plan
- LDR, base 0x100, offset 4, up, pre, no wb, zero-wait ack with `mem_rdata` 0xDEADBEEF:
  - `addr_sel` = 1 in cycles 1–2, `mem_addr` = 0x104;
  - `done` in cycle 3 with `load_data` = 0xDEADBEEF, `wb_valid` = 0.
- STR, base 0x200, offset 8, down, post-index, data 0x55AA, ack after 3 wait states:
  - `mem_addr` = 0x200, `mem_wdata` = 0x55AA;
  - `done` in cycle 6, `wb_valid` = 1, `wb_addr` = 0x1F8.
- LDR, base 0x0, offset 4, down, pre, wb:
  - `mem_addr` = 0xFFFFFFFC, `wb_addr` = 0xFFFFFFFC.
- No ack:
  - `done` and `err` in cycle 18 (`ACK_TIMEOUT` = 15);
  - `mem_re` drops, `wb_valid` = 0.
- `rst` asserted in the second ACCESS cycle:
  - next cycle all outputs 0, no `done`;
  - `req_ready` = 1 the cycle after `rst` deasserts.
- With `MEM_ALIGN_CHECK_EN`, LDR at 0x102:
  - `done` and `err` in cycle 2, `mem_re` never asserted.
